// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: three one-deep source buffers sharing the regfile write port.
// Optional build macro WB_FIXED_PRIO_EN selects fixed priority 0 > 1 > 2 instead of round-robin.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              ReqValid0,
    input  logic              ReqValid1,
    input  logic              ReqValid2,
    input  logic [ADDR_W-1:0] ReqAddr0,
    input  logic [ADDR_W-1:0] ReqAddr1,
    input  logic [ADDR_W-1:0] ReqAddr2,
    input  logic [DATA_W-1:0] ReqData0,
    input  logic [DATA_W-1:0] ReqData1,
    input  logic [DATA_W-1:0] ReqData2,
    output logic              ReqReady0,
    output logic              ReqReady1,
    output logic              ReqReady2,
    output logic              Write,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] ReadAddrA,
    input  logic [ADDR_W-1:0] ReadAddrB,
    output logic [NREG-1:0]   PendingMask,
    output logic              HazardA,
    output logic              HazardB
);

    logic [2:0]        w_req_v;
    logic [ADDR_W-1:0] w_req_a [3];
    logic [DATA_W-1:0] w_req_d [3];
    logic [2:0]        w_acc;
    logic [2:0]        w_gnt_oh;
    logic              w_gnt_v;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;
    logic [NREG-1:0]   w_pend;

    logic [2:0]        r_full;
    logic [ADDR_W-1:0] r_addr [3];
    logic [DATA_W-1:0] r_data [3];
    logic              r_write;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    assign w_req_v    = {ReqValid2, ReqValid1, ReqValid0};
    assign w_req_a[0] = ReqAddr0;
    assign w_req_a[1] = ReqAddr1;
    assign w_req_a[2] = ReqAddr2;
    assign w_req_d[0] = ReqData0;
    assign w_req_d[1] = ReqData1;
    assign w_req_d[2] = ReqData2;

    // A source is accepted only into an empty buffer, so accept and grant never collide.
    assign w_acc = w_req_v & ~r_full;

`ifdef WB_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered full buffer wins.
    always_comb begin
        w_gnt_oh = 3'b000;
        if (r_full[0]) begin
            w_gnt_oh = 3'b001;
        end else if (r_full[1]) begin
            w_gnt_oh = 3'b010;
        end else if (r_full[2]) begin
            w_gnt_oh = 3'b100;
        end
    end
`else
    logic [1:0] r_last;
    logic [1:0] w_ord [3];
    logic [1:0] w_gnt_idx;

    // Round-robin: search starts at the source after the last winner.
    always_comb begin
        w_gnt_oh = 3'b000;
        case (r_last)
            2'd0:    begin w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0; end
            2'd1:    begin w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1; end
            default: begin w_ord[0] = 2'd0; w_ord[1] = 2'd1; w_ord[2] = 2'd2; end
        endcase
        for (int k = 2; k >= 0; k--) begin
            if (r_full[w_ord[k]]) begin
                w_gnt_oh = 3'(3'b001 << w_ord[k]);
            end
        end
    end

    // Encode the winner for the round-robin pointer.
    always_comb begin
        w_gnt_idx = 2'd0;
        if (w_gnt_oh[1]) begin
            w_gnt_idx = 2'd1;
        end else if (w_gnt_oh[2]) begin
            w_gnt_idx = 2'd2;
        end
    end

    // Remember the last winner; reset value 2 gives source 0 first turn.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last <= 2'd2;
        end else if (w_gnt_v) begin
            r_last <= w_gnt_idx;
        end
    end
`endif

    assign w_gnt_v = |w_gnt_oh;

    // Select the winning buffer's address and data.
    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_gnt_oh[i]) begin
                w_gnt_addr = r_addr[i];
                w_gnt_data = r_data[i];
            end
        end
    end

    // Per-source buffers: fill on accept, free on grant.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_full <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_acc[i]) begin
                    r_full[i] <= 1'b1;
                    r_addr[i] <= w_req_a[i];
                    r_data[i] <= w_req_d[i];
                end else if (w_gnt_oh[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Registered regfile write port; address/data hold when idle.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_write <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_gnt_v) begin
            r_write <= 1'b1;
            r_waddr <= w_gnt_addr;
            r_wdata <= w_gnt_data;
        end else begin
            r_write <= 1'b0;
        end
    end

    // Destinations still buffered or sitting on the output stage.
    always_comb begin
        w_pend = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int i = 0; i < 3; i++) begin
                if (r_full[i] && (r_addr[i] == ADDR_W'(r))) begin
                    w_pend[r] = 1'b1;
                end
            end
            if (r_write && (r_waddr == ADDR_W'(r))) begin
                w_pend[r] = 1'b1;
            end
        end
    end

    assign ReqReady0   = ~r_full[0];
    assign ReqReady1   = ~r_full[1];
    assign ReqReady2   = ~r_full[2];
    assign Write       = r_write;
    assign WriteAddr   = r_waddr;
    assign DataIn      = r_wdata;
    assign PendingMask = w_pend;
    assign HazardA     = w_pend[ReadAddrA];
    assign HazardB     = w_pend[ReadAddrB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Expected writes are queued at stimulus time and checked by a write monitor.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0, ReqValid2 = 1'b0;
    logic [3:0]  ReqAddr0 = '0, ReqAddr1 = '0, ReqAddr2 = '0;
    logic [15:0] ReqData0 = '0, ReqData1 = '0, ReqData2 = '0;
    logic        ReqReady0, ReqReady1, ReqReady2;
    logic        Write;
    logic [3:0]  WriteAddr;
    logic [15:0] DataIn;
    logic [3:0]  ReadAddrA = '0, ReadAddrB = '0;
    logic [15:0] PendingMask;
    logic        HazardA, HazardB;

    int          total = 0;
    int          bad = 0;
    logic [19:0] q[$];
    logic [19:0] mon_exp;
    logic [15:0] rf [16] = '{default: 16'h0000};

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .NREG(16)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .ReqValid0(ReqValid0), .ReqValid1(ReqValid1), .ReqValid2(ReqValid2),
        .ReqAddr0(ReqAddr0), .ReqAddr1(ReqAddr1), .ReqAddr2(ReqAddr2),
        .ReqData0(ReqData0), .ReqData1(ReqData1), .ReqData2(ReqData2),
        .ReqReady0(ReqReady0), .ReqReady1(ReqReady1), .ReqReady2(ReqReady2),
        .Write(Write), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .PendingMask(PendingMask), .HazardA(HazardA), .HazardB(HazardB)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file fed by the write port.
    always @(posedge CLK) begin
        if (Write) rf[WriteAddr] <= DataIn;
    end

    // Write monitor: every write cycle must match the head of the queue.
    always @(negedge CLK) begin
        if (Write) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%h:%h want=none", WriteAddr, DataIn);
            end else begin
                mon_exp = q.pop_front();
                if ({WriteAddr, DataIn} !== mon_exp) begin
                    bad++;
                    $display("FAIL write_order got=%h:%h want=%h:%h",
                             WriteAddr, DataIn, mon_exp[19:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic do_reset;
        @(negedge CLK);
        Reset_n = 1'b0;
        ReqValid0 = 0; ReqValid1 = 0; ReqValid2 = 0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d want=0", q.size());
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({Write, PendingMask, ReqReady2, ReqReady1, ReqReady0} !== {1'b0, 16'h0, 3'b111}) begin
            bad++;
            $display("FAIL reset_initial got=%b/%h/%b want=0/0000/111",
                     Write, PendingMask, {ReqReady2, ReqReady1, ReqReady0});
        end
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd3; ReqData0 = 16'hBEEF;
        @(posedge CLK);
        #2;
        ReqValid0 = 0;
        total++;
        if (PendingMask !== 16'h0008 || ReqReady0 !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_state got=%h/%b want=0008/0", PendingMask, ReqReady0);
        end
        Reset_n = 1'b0;
        #1;
        total++;
        if ({Write, PendingMask, ReqReady2, ReqReady1, ReqReady0} !== {1'b0, 16'h0, 3'b111}) begin
            bad++;
            $display("FAIL reset_async got=%b/%h/%b want=0/0000/111",
                     Write, PendingMask, {ReqReady2, ReqReady1, ReqReady0});
        end
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({Write, PendingMask, ReqReady2, ReqReady1, ReqReady0} !== {1'b0, 16'h0, 3'b111}
            || rf[3] !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release got=%b/%h/%b/%h want=0/0000/111/0000",
                     Write, PendingMask, {ReqReady2, ReqReady1, ReqReady0}, rf[3]);
        end
    endtask

    task automatic test_single;
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd5; ReqData0 = 16'h1234;
        q.push_back({4'd5, 16'h1234});
        @(negedge CLK);
        ReqValid0 = 0;
        total++;
        if ({ReqReady0, Write, PendingMask} !== {1'b0, 1'b0, 16'h0020}) begin
            bad++;
            $display("FAIL single_accept got=%b/%b/%h want=0/0/0020", ReqReady0, Write, PendingMask);
        end
        @(negedge CLK);
        total++;
        if ({ReqReady0, Write, PendingMask} !== {1'b1, 1'b1, 16'h0020}) begin
            bad++;
            $display("FAIL single_issue got=%b/%b/%h want=1/1/0020", ReqReady0, Write, PendingMask);
        end
        @(negedge CLK);
        total++;
        if ({Write, PendingMask, rf[5]} !== {1'b0, 16'h0, 16'h1234}) begin
            bad++;
            $display("FAIL single_done got=%b/%h/%h want=0/0000/1234", Write, PendingMask, rf[5]);
        end
    endtask

    task automatic test_contention;
        do_reset();
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd1; ReqData0 = 16'h0001;
        ReqValid1 = 1; ReqAddr1 = 4'd2; ReqData1 = 16'h0002;
        ReqValid2 = 1; ReqAddr2 = 4'd3; ReqData2 = 16'h0003;
        q.push_back({4'd1, 16'h0001});
        q.push_back({4'd2, 16'h0002});
        q.push_back({4'd3, 16'h0003});
        @(negedge CLK);
        ReqValid0 = 0; ReqValid1 = 0; ReqValid2 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            total++;
            if (Write !== 1'b1) begin
                bad++;
                $display("FAIL contention_burst cycle=%0d got=%b want=1", c, Write);
            end
        end
        @(negedge CLK);
        total++;
        if (Write !== 1'b0 || PendingMask !== 16'h0) begin
            bad++;
            $display("FAIL contention_end got=%b/%h want=0/0000", Write, PendingMask);
        end
        wait_drain(4);
    endtask

    task automatic test_alternate;
        int k0 = 0;
        int k1 = 0;
        int cyc = 0;
        logic a0, a1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q.push_back({4'd10, 16'h0A00 + 16'(k)});
            q.push_back({4'd11, 16'h0B00 + 16'(k)});
        end
        while ((k0 < 4 || k1 < 4) && cyc < 40) begin
            @(negedge CLK);
            ReqValid0 = (k0 < 4); ReqAddr0 = 4'd10; ReqData0 = 16'h0A00 + 16'(k0);
            ReqValid1 = (k1 < 4); ReqAddr1 = 4'd11; ReqData1 = 16'h0B00 + 16'(k1);
            a0 = ReqValid0 & ReqReady0;
            a1 = ReqValid1 & ReqReady1;
            @(posedge CLK);
            if (a0) k0++;
            if (a1) k1++;
            cyc++;
        end
        @(negedge CLK);
        ReqValid0 = 0; ReqValid1 = 0;
        total++;
        if (k0 != 4 || k1 != 4) begin
            bad++;
            $display("FAIL alternate_accepts got=%0d/%0d want=4/4", k0, k1);
        end
        wait_drain(12);
    endtask

    task automatic test_hazard;
        ReadAddrA = 4'd7; ReadAddrB = 4'd8;
        @(negedge CLK);
        ReqValid2 = 1; ReqAddr2 = 4'd7; ReqData2 = 16'h7777;
        q.push_back({4'd7, 16'h7777});
        @(negedge CLK);
        ReqValid2 = 0;
        total++;
        if ({HazardA, HazardB} !== 2'b10) begin
            bad++;
            $display("FAIL hazard_buffered got=%b%b want=10", HazardA, HazardB);
        end
        @(negedge CLK);
        total++;
        if ({Write, HazardA, HazardB} !== 3'b110) begin
            bad++;
            $display("FAIL hazard_issue got=%b/%b%b want=1/10", Write, HazardA, HazardB);
        end
        @(negedge CLK);
        total++;
        if ({Write, HazardA, HazardB} !== 3'b000) begin
            bad++;
            $display("FAIL hazard_clear got=%b/%b%b want=0/00", Write, HazardA, HazardB);
        end
        wait_drain(2);
    endtask

    task automatic test_same_addr;
        do_reset();
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd9; ReqData0 = 16'h0909;
        q.push_back({4'd9, 16'h0909});
        @(negedge CLK);
        ReqValid0 = 0;
        wait_drain(4);
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd4; ReqData0 = 16'h5555;
        ReqValid1 = 1; ReqAddr1 = 4'd4; ReqData1 = 16'hAAAA;
        q.push_back({4'd4, 16'hAAAA});
        q.push_back({4'd4, 16'h5555});
        @(negedge CLK);
        ReqValid0 = 0; ReqValid1 = 0;
        wait_drain(6);
        total++;
        if (rf[4] !== 16'h5555) begin
            bad++;
            $display("FAIL same_addr_final got=%h want=5555", rf[4]);
        end
    endtask

    task automatic test_reset_midop;
        do_reset();
        @(negedge CLK);
        ReqValid0 = 1; ReqAddr0 = 4'd12; ReqData0 = 16'hCCCC;
        ReqValid1 = 1; ReqAddr1 = 4'd13; ReqData1 = 16'hDDDD;
        ReqValid2 = 1; ReqAddr2 = 4'd14; ReqData2 = 16'hEEEE;
        @(posedge CLK);
        #1;
        ReqValid0 = 0; ReqValid1 = 0; ReqValid2 = 0;
        @(posedge CLK);
        #1;
        total++;
        if ({Write, WriteAddr} !== {1'b1, 4'd12}) begin
            bad++;
            $display("FAIL midop_issue got=%b/%h want=1/c", Write, WriteAddr);
        end
        #1;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({Write, PendingMask, ReqReady2, ReqReady1, ReqReady0} !== {1'b0, 16'h0, 3'b111}) begin
            bad++;
            $display("FAIL midop_reset got=%b/%h/%b want=0/0000/111",
                     Write, PendingMask, {ReqReady2, ReqReady1, ReqReady0});
        end
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        repeat (6) @(negedge CLK);
        total++;
        if ({rf[12], rf[13], rf[14]} !== 48'h0 || Write !== 1'b0) begin
            bad++;
            $display("FAIL midop_regfile got=%h/%h/%h/%b want=0000/0000/0000/0",
                     rf[12], rf[13], rf[14], Write);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_alternate();
        test_hazard();
        test_same_addr();
        test_reset_midop();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_leftover got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
